serial_addsub: RTL and testbench

- Bit-serial N-bit adder/subtractor built around one full-adder cell, reused once per clock.
- Accepts two operands and a mode bit, processes one bit per cycle LSB-first, and returns result, carry-out and signed overflow with a done pulse.
- Wider arithmetic is built from the single-bit full-adder cell by iterating it in time rather than replicating it in space.
- Subtract mode is the inverse operation on the same datapath.

---
 rtl/serial_addsub.sv | 133 +++++++++++++
 tb/tb_serial_addsub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell reused LSB-first.
// Optional zero-result flag enabled by defining SERIAL_ADDSUB_ZERO_FLAG_EN.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    output logic             overflow,
    output logic             zero
`else
    output logic             overflow
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(WIDTH - 2);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cin_msb;
    logic             r_cout;
    logic             r_ovf;

    logic w_s;
    logic w_c;
    logic w_accept;
    logic w_last;

    // The single full-adder cell, fed from the LSBs of the shift registers.
    assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_c = (r_opa[0] & r_opb[0]) |
                 (r_opa[0] & r_carry) |
                 (r_opb[0] & r_carry);

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_opa     <= '0;
            r_opb     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B, seed carry with 1.
                        r_opa    <= a;
                        r_opb    <= b ^ {WIDTH{sub}};
                        r_carry  <= sub;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result <= {w_s, r_result[WIDTH-1:1]};
                    r_opa    <= r_opa >> 1;
                    r_opb    <= r_opb >> 1;
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_PREV) begin
                        r_cin_msb <= w_c;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_cout  <= w_c;
                        r_ovf   <= r_cin_msb ^ w_c;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic r_zacc;
    logic r_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zacc <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zacc <= 1'b0;
            r_zero <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_zacc <= r_zacc | w_s;
            if (w_last) begin
                r_zero <= ~(r_zacc | w_s);
            end
        end
    end

    assign zero = r_zero;
`endif

    assign busy     = (r_state == S_RUN) || (r_state == S_DONE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): arithmetic model plus
// directed vectors; build with SERIAL_ADDSUB_ZERO_FLAG_EN to cover zero.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        .overflow (overflow),
        .zero     (zero)
`else
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: age counts edges since acceptance (-1 when idle).
    int           m_age = -1;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_zero = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age  = -1;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            m_zero = 1'b0;
        end else if (m_age < 0) begin
            if (start) begin
                int unsigned ua, ub, sum;
                logic sa, sb, sr;
                ua  = a;
                ub  = b;
                sum = sub ? (ua - ub + 256) : (ua + ub);
                m_res  = sum[W-1:0];
                m_cout = sum[W];
                sa = a[W-1];
                sb = b[W-1];
                sr = m_res[W-1];
                m_ovf  = sub ? ((sa != sb) && (sr != sa))
                             : ((sa == sb) && (sr != sa));
                m_zero = (m_res == 0);
                m_age  = 0;
            end
        end else if (m_age == W) begin
            m_age = -1;
        end else begin
            m_age = m_age + 1;
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_age >= 0);
        check("done", done, m_age == W);
        if (m_age == W || m_age < 0) begin
            check("m_result", result, m_res);
            check("m_cout", cout, m_cout);
            check("m_ovf", overflow, m_ovf);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            check("m_zero", zero, m_zero);
`endif
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, input logic [W-1:0] er,
                          input logic ec, input logic eo);
        int edges = 0;
        bit seen = 0;
        @(posedge clk);
        #2;
        a = ia; b = ib; sub = isub; start = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            edges++;
            if (edges == 1) begin
                #2 start = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1;
        end
        check("latency", edges, W + 1);
        check("result", result, er);
        check("cout", cout, ec);
        check("ovf", overflow, eo);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        check("zero", zero, er == 0);
`endif
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc[$];
        int nidle;
        int ndone;
        logic [W-1:0] res_at_done;

        #1 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0);

        // Start while busy must be ignored.
        @(posedge clk);
        #2 a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        ndone = 0;
        res_at_done = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                res_at_done = result;
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_result", res_at_done, 8'h30);
        check("ign_busy", busy, 0);

        // Back-to-back with start held high.
        @(posedge clk);
        #2 a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        nidle = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done) dcyc.push_back(i);
            if (!busy && dcyc.size() == 1) nidle++;
        end
        #1 start = 1'b0;
        check("b2b_ndone", dcyc.size() >= 3, 1);
        if (dcyc.size() >= 3) begin
            check("b2b_gap1", dcyc[1] - dcyc[0], W + 2);
            check("b2b_gap2", dcyc[2] - dcyc[1], W + 2);
        end
        check("b2b_idle", nidle, 1);
        wait_idle();

        // Async reset mid-operation.
        @(posedge clk);
        #2 a = 8'h7F; b = 8'h7F; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_result", result, 0);
        check("ar_cout", cout, 0);
        check("ar_ovf", overflow, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
